mem_responder: RTL and testbench

Memory-side responder for the processor's MAR/MDR memory interface. It accepts one access request at a time from the datapath control unit, performs byte, halfword, or word reads and writes on a byte-addressed big-endian array after a programmable wait, and signals completion with MFC (memory function complete). It replaces the zero-latency RAM model so that the control unit's MFC wait states are actually exercised. It also reports misaligned accesses so the trap logic can raise a mem_address_not_aligned trap.

---
 rtl/mem_responder.sv | 200 ++++++++++++++++++++
 tb/tb_mem_responder.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Memory-side responder for the MAR/MDR interface: big-endian byte array with
// programmable wait states, byte/halfword/word access, MFC handshake and misalignment report.
module mem_responder #(
    parameter int DEPTH       = 256,
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              Clk,
    input  logic              Clr,
    input  logic              Enable,
    input  logic              RW,
    input  logic [1:0]        Size,
    input  logic              Signed,
    input  logic [ADDR_W-1:0] Address,
    input  logic [31:0]       DataIn,
    output logic [31:0]       DataOut,
    output logic              MFC,
    output logic              Misaligned
);

    localparam int LANE_DEPTH = DEPTH / 4;
    localparam int IDX_W      = ADDR_W - 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACCESS,
        ST_DONE
    } state_t;

    state_t              state_reg, state_next;
    logic [3:0]          count_reg, count_next;
    logic                rw_reg, rw_next;
    logic [1:0]          size_reg, size_next;
    logic                signed_reg, signed_next;
    logic [ADDR_W-1:0]   addr_reg, addr_next;
    logic [31:0]         din_reg, din_next;
    logic [31:0]         dout_reg, dout_next;
    logic                mfc_reg, mfc_next;
    logic                mis_reg, mis_next;

    // Lane k holds the byte at address 4*w+k, so lane 0 is the most significant byte of a word.
    logic [3:0][7:0]     rd_lane;
    logic [3:0][7:0]     wr_lane;
    logic [3:0]          wr_en;
    logic [IDX_W-1:0]    rd_idx;
    logic [IDX_W-1:0]    wr_idx;

    logic                misaligned_req;
    logic [7:0]          rd_byte;
    logic [15:0]         rd_half;
    logic [31:0]         rd_word;
    logic [31:0]         read_data;

    // The lane read is issued on the edge that enters ACCESS; from IDLE that is the request edge.
    assign rd_idx = (state_reg == ST_IDLE) ? Address[ADDR_W-1:2] : addr_reg[ADDR_W-1:2];
    assign wr_idx = addr_reg[ADDR_W-1:2];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] mem [LANE_DEPTH];
            logic [7:0] rd_q;

            always_ff @(posedge Clk) begin
                if (wr_en[gi]) begin
                    mem[wr_idx] <= wr_lane[gi];
                end
                rd_q <= mem[rd_idx];
            end

            assign rd_lane[gi] = rd_q;
        end
    endgenerate

    always_comb begin
        misaligned_req = 1'b0;
        if (size_reg == 2'b01) begin
            misaligned_req = addr_reg[0];
        end else if (size_reg[1]) begin
            misaligned_req = |addr_reg[1:0];
        end
    end

    always_comb begin
        rd_byte = rd_lane[addr_reg[1:0]];
        rd_half = {rd_lane[{addr_reg[1], 1'b0}], rd_lane[{addr_reg[1], 1'b1}]};
        rd_word = {rd_lane[0], rd_lane[1], rd_lane[2], rd_lane[3]};
        case (size_reg)
            2'b00:   read_data = {{24{signed_reg & rd_byte[7]}}, rd_byte};
            2'b01:   read_data = {{16{signed_reg & rd_half[15]}}, rd_half};
            default: read_data = rd_word;
        endcase
    end

    always_comb begin
        wr_en   = '0;
        wr_lane = '0;
        if (state_reg == ST_ACCESS && !rw_reg && !misaligned_req) begin
            case (size_reg)
                2'b00: begin
                    wr_en[addr_reg[1:0]]   = 1'b1;
                    wr_lane[addr_reg[1:0]] = din_reg[7:0];
                end
                2'b01: begin
                    wr_en[{addr_reg[1], 1'b0}]   = 1'b1;
                    wr_en[{addr_reg[1], 1'b1}]   = 1'b1;
                    wr_lane[{addr_reg[1], 1'b0}] = din_reg[15:8];
                    wr_lane[{addr_reg[1], 1'b1}] = din_reg[7:0];
                end
                default: begin
                    wr_en = 4'hF;
                    for (int k = 0; k < 4; k++) begin
                        wr_lane[k] = din_reg[31-8*k -: 8];
                    end
                end
            endcase
        end
    end

    always_comb begin
        state_next  = state_reg;
        count_next  = count_reg;
        rw_next     = rw_reg;
        size_next   = size_reg;
        signed_next = signed_reg;
        addr_next   = addr_reg;
        din_next    = din_reg;
        dout_next   = dout_reg;
        mfc_next    = mfc_reg;
        mis_next    = mis_reg;
        case (state_reg)
            ST_IDLE: begin
                if (Enable) begin
                    rw_next     = RW;
                    size_next   = Size;
                    signed_next = Signed;
                    addr_next   = Address;
                    din_next    = DataIn;
                    count_next  = 4'(WAIT_CYCLES);
                    state_next  = (WAIT_CYCLES == 0) ? ST_ACCESS : ST_WAIT;
                end
            end
            ST_WAIT: begin
                count_next = count_reg - 4'd1;
                if (count_reg <= 4'd1) begin
                    state_next = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                mfc_next   = 1'b1;
                mis_next   = misaligned_req;
                state_next = ST_DONE;
                if (rw_reg && !misaligned_req) begin
                    dout_next = read_data;
                end
            end
            ST_DONE: begin
                // Completion holds until the initiator withdraws its request.
                if (!Enable) begin
                    mfc_next   = 1'b0;
                    mis_next   = 1'b0;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            state_reg  <= ST_IDLE;
            count_reg  <= 4'd0;
            rw_reg     <= 1'b0;
            size_reg   <= 2'b00;
            signed_reg <= 1'b0;
            addr_reg   <= '0;
            din_reg    <= 32'd0;
            dout_reg   <= 32'd0;
            mfc_reg    <= 1'b0;
            mis_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            count_reg  <= count_next;
            rw_reg     <= rw_next;
            size_reg   <= size_next;
            signed_reg <= signed_next;
            addr_reg   <= addr_next;
            din_reg    <= din_next;
            dout_reg   <= dout_next;
            mfc_reg    <= mfc_next;
            mis_reg    <= mis_next;
        end
    end

    assign DataOut    = dout_reg;
    assign MFC        = mfc_reg;
    assign Misaligned = mis_reg;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one instance with WAIT_CYCLES=2, one with WAIT_CYCLES=0.
module tb_mem_responder;

    localparam logic WR = 1'b0;
    localparam logic RD = 1'b1;

    logic        clk;
    logic        clr;
    logic        en_a, en_b;
    logic        rw;
    logic [1:0]  size;
    logic        sgn;
    logic [7:0]  addr;
    logic [31:0] din;
    logic [31:0] dout_a, dout_b;
    logic        mfc_a, mfc_b;
    logic        mis_a, mis_b;

    int checks = 0;
    int errors = 0;

    mem_responder #(.DEPTH(256), .ADDR_W(8), .WAIT_CYCLES(2)) dut_a (
        .Clk(clk), .Clr(clr), .Enable(en_a), .RW(rw), .Size(size), .Signed(sgn),
        .Address(addr), .DataIn(din), .DataOut(dout_a), .MFC(mfc_a), .Misaligned(mis_a)
    );

    mem_responder #(.DEPTH(256), .ADDR_W(8), .WAIT_CYCLES(0)) dut_b (
        .Clk(clk), .Clr(clr), .Enable(en_b), .RW(rw), .Size(size), .Signed(sgn),
        .Address(addr), .DataIn(din), .DataOut(dout_b), .MFC(mfc_b), .Misaligned(mis_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        sel;
        logic        rw;
        logic [1:0]  size;
        logic        sgn;
        logic [7:0]  addr;
        logic [31:0] din;
        logic [31:0] exp_dout;
        logic        exp_mis;
    } vec_t;

    vec_t vecs[25];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Issue one request, wait for MFC (bounded), then withdraw Enable for one edge.
    task automatic run_access(input logic sel_i, input logic rw_i, input logic [1:0] size_i,
                              input logic sgn_i, input logic [7:0] addr_i, input logic [31:0] din_i,
                              output logic [31:0] dout_o, output logic mis_o, output int edges_o);
        rw = rw_i; size = size_i; sgn = sgn_i; addr = addr_i; din = din_i;
        if (sel_i) en_b = 1'b1; else en_a = 1'b1;
        edges_o = -1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if ((sel_i ? mfc_b : mfc_a) === 1'b1) begin
                edges_o = i;
                break;
            end
        end
        dout_o = sel_i ? dout_b : dout_a;
        mis_o  = sel_i ? mis_b : mis_a;
        en_a = 1'b0; en_b = 1'b0;
        @(posedge clk); #1;
        check("mfc_release", 32'(sel_i ? mfc_b : mfc_a), 32'd0);
        check("mis_release", 32'(sel_i ? mis_b : mis_a), 32'd0);
    endtask

    initial begin
        logic [31:0] d;
        logic        m;
        int          e;
        int          pulses;

        vecs[0]  = '{1'b0, WR, 2'd2, 1'b0, 8'h10, 32'hDEADBEEF, 32'h00000000, 1'b0};
        vecs[1]  = '{1'b0, RD, 2'd2, 1'b0, 8'h10, 32'h0,        32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b0, RD, 2'd0, 1'b0, 8'h10, 32'h0,        32'h000000DE, 1'b0};
        vecs[3]  = '{1'b0, RD, 2'd0, 1'b0, 8'h13, 32'h0,        32'h000000EF, 1'b0};
        vecs[4]  = '{1'b0, RD, 2'd0, 1'b1, 8'h11, 32'h0,        32'hFFFFFFAD, 1'b0};
        vecs[5]  = '{1'b0, RD, 2'd1, 1'b0, 8'h12, 32'h0,        32'h0000BEEF, 1'b0};
        vecs[6]  = '{1'b0, RD, 2'd1, 1'b1, 8'h12, 32'h0,        32'hFFFFBEEF, 1'b0};
        vecs[7]  = '{1'b0, WR, 2'd2, 1'b0, 8'h20, 32'h11223344, 32'hFFFFBEEF, 1'b0};
        vecs[8]  = '{1'b0, WR, 2'd2, 1'b0, 8'h22, 32'h12345678, 32'hFFFFBEEF, 1'b1};
        vecs[9]  = '{1'b0, RD, 2'd2, 1'b0, 8'h20, 32'h0,        32'h11223344, 1'b0};
        vecs[10] = '{1'b0, RD, 2'd1, 1'b0, 8'h21, 32'h0,        32'h11223344, 1'b1};
        vecs[11] = '{1'b0, WR, 2'd2, 1'b0, 8'h30, 32'h01020304, 32'h11223344, 1'b0};
        vecs[12] = '{1'b0, WR, 2'd1, 1'b0, 8'h32, 32'h0000A5C3, 32'h11223344, 1'b0};
        vecs[13] = '{1'b0, WR, 2'd0, 1'b0, 8'h31, 32'hABCDEF7F, 32'h11223344, 1'b0};
        vecs[14] = '{1'b0, RD, 2'd2, 1'b0, 8'h30, 32'h0,        32'h017FA5C3, 1'b0};
        vecs[15] = '{1'b0, RD, 2'd0, 1'b1, 8'h31, 32'h0,        32'h0000007F, 1'b0};
        vecs[16] = '{1'b0, RD, 2'd3, 1'b0, 8'h30, 32'h0,        32'h017FA5C3, 1'b0};
        vecs[17] = '{1'b0, WR, 2'd3, 1'b0, 8'h31, 32'h99999999, 32'h017FA5C3, 1'b1};
        vecs[18] = '{1'b0, RD, 2'd0, 1'b1, 8'h32, 32'h0,        32'hFFFFFFA5, 1'b0};
        vecs[19] = '{1'b0, RD, 2'd1, 1'b1, 8'h30, 32'h0,        32'h0000017F, 1'b0};
        vecs[20] = '{1'b1, WR, 2'd2, 1'b0, 8'hFC, 32'hCAFEF00D, 32'h00000000, 1'b0};
        vecs[21] = '{1'b1, RD, 2'd2, 1'b0, 8'hFC, 32'h0,        32'hCAFEF00D, 1'b0};
        vecs[22] = '{1'b1, RD, 2'd0, 1'b0, 8'hFF, 32'h0,        32'h0000000D, 1'b0};
        vecs[23] = '{1'b1, RD, 2'd1, 1'b1, 8'hFE, 32'h0,        32'hFFFFF00D, 1'b0};
        vecs[24] = '{1'b1, RD, 2'd0, 1'b1, 8'hFC, 32'h0,        32'hFFFFFFCA, 1'b0};

        clr = 1'b1; en_a = 1'b0; en_b = 1'b0;
        rw = 1'b0; size = 2'd0; sgn = 1'b0; addr = 8'h0; din = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_mfc_a", 32'(mfc_a), 32'd0);
        check("reset_mis_a", 32'(mis_a), 32'd0);
        check("reset_dout_a", dout_a, 32'd0);
        check("reset_mfc_b", 32'(mfc_b), 32'd0);
        check("reset_dout_b", dout_b, 32'd0);
        clr = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 25; i++) begin
            run_access(vecs[i].sel, vecs[i].rw, vecs[i].size, vecs[i].sgn, vecs[i].addr,
                       vecs[i].din, d, m, e);
            $display("vec %0d: dut=%0d rw=%0d size=%0d sgn=%0d addr=%h din=%h -> dout=%h mis=%0d edges=%0d",
                     i, vecs[i].sel, vecs[i].rw, vecs[i].size, vecs[i].sgn, vecs[i].addr,
                     vecs[i].din, d, m, e);
            check($sformatf("vec%0d_dout", i), d, vecs[i].exp_dout);
            check($sformatf("vec%0d_mis", i), 32'(m), 32'(vecs[i].exp_mis));
            check($sformatf("vec%0d_latency", i), 32'(e), vecs[i].sel ? 32'd1 : 32'd3);
        end

        // Enable held high past MFC: completion holds, no second access.
        rw = WR; size = 2'd2; sgn = 1'b0; addr = 8'h50; din = 32'h11111111; en_a = 1'b1;
        e = -1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (mfc_a === 1'b1) begin
                e = i;
                break;
            end
        end
        check("hold_latency", 32'(e), 32'd3);
        din = 32'h22222222;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("hold_mfc", 32'(mfc_a), 32'd1);
        end
        en_a = 1'b0;
        @(posedge clk); #1;
        check("hold_release", 32'(mfc_a), 32'd0);
        run_access(1'b0, RD, 2'd2, 1'b0, 8'h50, 32'h0, d, m, e);
        $display("hold: readback addr=50 dout=%h", d);
        check("hold_readback", d, 32'h11111111);

        // Enable dropped during WAIT: access completes with a one-cycle MFC.
        rw = WR; size = 2'd2; addr = 8'h60; din = 32'h87654321; en_a = 1'b1;
        @(posedge clk); #1;
        en_a = 1'b0;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (mfc_a === 1'b1) pulses++;
        end
        $display("drop: mfc high for %0d cycles", pulses);
        check("drop_pulses", 32'(pulses), 32'd1);
        run_access(1'b0, RD, 2'd2, 1'b0, 8'h60, 32'h0, d, m, e);
        check("drop_readback", d, 32'h87654321);

        // Reset during WAIT of a write.
        run_access(1'b0, WR, 2'd2, 1'b0, 8'h40, 32'h5A5A5A5A, d, m, e);
        run_access(1'b0, RD, 2'd2, 1'b0, 8'h40, 32'h0, d, m, e);
        check("pre_reset_read", d, 32'h5A5A5A5A);
        rw = WR; size = 2'd2; addr = 8'h40; din = 32'hAAAAAAAA; en_a = 1'b1;
        @(posedge clk); #1;
        clr = 1'b1;
        #1;
        check("clr_wait_mfc", 32'(mfc_a), 32'd0);
        check("clr_wait_mis", 32'(mis_a), 32'd0);
        check("clr_wait_dout", dout_a, 32'd0);
        en_a = 1'b0;
        @(posedge clk); #1;
        clr = 1'b0;
        @(posedge clk); #1;
        check("post_clr_dout", dout_a, 32'd0);
        run_access(1'b0, RD, 2'd2, 1'b0, 8'h40, 32'h0, d, m, e);
        $display("reset: readback addr=40 dout=%h", d);
        check("clr_write_dropped", d, 32'h5A5A5A5A);
        run_access(1'b0, RD, 2'd2, 1'b0, 8'h10, 32'h0, d, m, e);
        check("clr_survivor", d, 32'hDEADBEEF);

        // Reset while holding a misaligned completion in DONE.
        rw = WR; size = 2'd2; addr = 8'h23; din = 32'h0; en_a = 1'b1;
        e = -1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (mfc_a === 1'b1) begin
                e = i;
                break;
            end
        end
        check("done_mis_before_clr", 32'(mis_a), 32'd1);
        #2;
        clr = 1'b1;
        #1;
        $display("reset in done: mfc=%0d mis=%0d dout=%h", mfc_a, mis_a, dout_a);
        check("clr_done_mfc", 32'(mfc_a), 32'd0);
        check("clr_done_mis", 32'(mis_a), 32'd0);
        check("clr_done_dout", dout_a, 32'd0);
        en_a = 1'b0;
        @(posedge clk); #1;
        clr = 1'b0;
        @(posedge clk); #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
